// File: rtl/online_to_conventional_converter.sv
// On-the-fly (Q/QM) converter: folds an MSD-first signed-digit stream into a
// two's-complement integer without ever performing a carry-propagate addition.
module online_to_conventional_converter #(
  parameter int no_of_digits = 9,
  parameter int radix_bits   = 3,
  parameter int radix        = 4
) (
  input  logic                    clk,
  input  logic                    extern_reset_n,
  input  logic [radix_bits-1:0]   z,
  input  logic                    z_valid,
  input  logic                    z_first,
  output logic [2*no_of_digits:0] result,
  output logic                    result_valid,
  output logic                    busy,
  output logic                    digit_error
);

  localparam int W           = 2*no_of_digits + 1;
  localparam int DIGIT_SHIFT = $clog2(radix);
  localparam int CW          = (no_of_digits > 1) ? $clog2(no_of_digits) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(no_of_digits - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, CONV = 1'b1} state_t;

  function automatic logic digit_illegal(input logic [radix_bits-1:0] d);
    return d == {1'b1, {(radix_bits-1){1'b0}}};
  endfunction

  function automatic logic [radix_bits-1:0] digit_clean(input logic [radix_bits-1:0] d);
    return digit_illegal(d) ? {radix_bits{1'b0}} : d;
  endfunction

  state_t                  state_q, state_d;
  logic [W-1:0]            q_q, q_d, qm_q, qm_d, result_q, result_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    result_valid_q, result_valid_d;
  logic                    busy_q, busy_d;
  logic                    digit_error_q, digit_error_d;

  logic                    start_s, accept_s, last_s, illegal_s, d_neg_s, d_pos_s;
  logic [radix_bits-1:0]   dig_s;
  logic [CW-1:0]           cnt_base_s;
  logic [W-1:0]            base_q_s, base_qm_s, q_src_s, qm_src_s, q_new_s, qm_new_s;
  logic [DIGIT_SHIFT-1:0]  q_low_s, qm_low_s;

  // Digit decode and the Q/QM append: the low bits come straight from the digit term
  always_comb begin
    start_s    = z_valid & z_first;
    accept_s   = z_valid & (z_first | (state_q == CONV));
    illegal_s  = digit_illegal(z);
    dig_s      = digit_clean(z);
    d_neg_s    = dig_s[radix_bits-1];
    d_pos_s    = ~d_neg_s & (dig_s != {radix_bits{1'b0}});
    cnt_base_s = start_s ? {CW{1'b0}} : cnt_q;
    last_s     = accept_s & (cnt_base_s == LAST_CNT);
    base_q_s   = start_s ? {W{1'b0}} : q_q;
    base_qm_s  = start_s ? {W{1'b1}} : qm_q;
    q_src_s    = d_neg_s ? base_qm_s : base_q_s;
    qm_src_s   = d_pos_s ? base_q_s : base_qm_s;
    // Both d and 4+d share low bits; d-1 and 3+d likewise, so one term each
    q_low_s    = dig_s[DIGIT_SHIFT-1:0];
    qm_low_s   = dig_s[DIGIT_SHIFT-1:0] - {{(DIGIT_SHIFT-1){1'b0}}, 1'b1};
    q_new_s    = (q_src_s << DIGIT_SHIFT) | W'(q_low_s);
    qm_new_s   = (qm_src_s << DIGIT_SHIFT) | W'(qm_low_s);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = last_s ? IDLE : CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        if (accept_s) begin
          state_d = last_s ? IDLE : CONV;
        end else begin
          state_d = CONV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    q_d            = q_q;
    qm_d           = qm_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    busy_d         = busy_q;
    digit_error_d  = digit_error_q;
    if (accept_s) begin
      q_d            = q_new_s;
      qm_d           = qm_new_s;
      cnt_d          = last_s ? {CW{1'b0}} : cnt_base_s + {{(CW-1){1'b0}}, 1'b1};
      result_d       = last_s ? q_new_s : result_q;
      result_valid_d = last_s;
      busy_d         = ~last_s;
      digit_error_d  = (start_s ? 1'b0 : digit_error_q) | illegal_s;
    end else begin
      result_valid_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge extern_reset_n) begin
    if (!extern_reset_n) begin
      state_q        <= IDLE;
      q_q            <= {W{1'b0}};
      qm_q           <= {W{1'b1}};
      cnt_q          <= {CW{1'b0}};
      result_q       <= {W{1'b0}};
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      digit_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      q_q            <= q_d;
      qm_q           <= qm_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      digit_error_q  <= digit_error_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign digit_error  = digit_error_q;

endmodule

// File: tb/tb_online_to_conventional_converter.sv
// Bench for the on-the-fly converter: vector table, hand-written corner
// sequences and random streams, all checked against a digit-list value model.
module tb_online_to_conventional_converter;

  localparam int N = 4;
  localparam int W = 2*N + 1;

  logic         clk = 1'b0;
  logic         extern_reset_n;
  logic [2:0]   z;
  logic         z_valid;
  logic         z_first;
  logic [W-1:0] result;
  logic         result_valid;
  logic         busy;
  logic         digit_error;

  int checks = 0;
  int errors = 0;

  int m_digits[$];
  bit m_active;
  bit m_err;
  bit exp_rv;
  int exp_result;

  typedef struct {
    logic [2:0] dig [N];
    int         gap;
    int         exp_val;
    bit         exp_err;
  } vec_t;
  vec_t tbl[$];

  online_to_conventional_converter #(.no_of_digits(N), .radix_bits(3), .radix(4)) dut (
    .clk(clk), .extern_reset_n(extern_reset_n), .z(z), .z_valid(z_valid), .z_first(z_first),
    .result(result), .result_valid(result_valid), .busy(busy), .digit_error(digit_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                         input logic [2:0] e, input int gap, input int val, input bit err);
    vec_t v;
    v.dig[0] = a; v.dig[1] = b; v.dig[2] = c; v.dig[3] = e;
    v.gap = gap; v.exp_val = val; v.exp_err = err;
    tbl.push_back(v);
  endtask

  // Value of the digit string = Horner sum of the accepted digits (illegal -> 0)
  task automatic model_step(input bit v, input bit f, input logic [2:0] d);
    int dv;
    exp_rv = 1'b0;
    if (v && (f || m_active)) begin
      if (f) begin
        m_digits.delete();
        m_err = 1'b0;
      end
      if (d == 3'b100) begin
        dv = 0;
        m_err = 1'b1;
      end else begin
        dv = int'($signed(d));
      end
      m_digits.push_back(dv);
      m_active = 1'b1;
      if (m_digits.size() == N) begin
        exp_result = 0;
        foreach (m_digits[i]) exp_result = exp_result * 4 + m_digits[i];
        exp_rv = 1'b1;
        m_active = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_digits.delete();
    m_active = 1'b0;
    m_err = 1'b0;
    exp_rv = 1'b0;
    exp_result = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "/result"}, int'($signed(result)), exp_result);
    check({tag, "/result_valid"}, int'(result_valid), int'(exp_rv));
    check({tag, "/busy"}, int'(busy), int'(m_active));
    check({tag, "/digit_error"}, int'(digit_error), int'(m_err));
  endtask

  task automatic cycle(input bit v, input bit f, input logic [2:0] d, input string tag);
    z_valid = v;
    z_first = f;
    z = d;
    model_step(v, f, d);
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic gaps(input int n);
    for (int g = 0; g < n; g++) cycle(1'b0, 1'b0, 3'd0, "gap");
  endtask

  task automatic do_reset();
    #2;
    extern_reset_n = 1'b0;
    z_valid = 1'b0;
    z_first = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    check_outputs("rst_hold");
    extern_reset_n = 1'b1;
  endtask

  initial begin
    extern_reset_n = 1'b0;
    z = 3'd0;
    z_valid = 1'b0;
    z_first = 1'b0;
    model_reset();

    add_vec(3'd1, 3'd0, 3'd0, 3'd0, 0,   64, 1'b0);
    add_vec(3'd7, 3'd0, 3'd0, 3'd0, 0,  -64, 1'b0);
    add_vec(3'd0, 3'd0, 3'd0, 3'd7, 1,   -1, 1'b0);
    add_vec(3'd1, 3'd5, 3'd5, 3'd5, 0,    1, 1'b0);
    add_vec(3'd3, 3'd3, 3'd3, 3'd3, 2,  255, 1'b0);
    add_vec(3'd5, 3'd5, 3'd5, 3'd5, 0, -255, 1'b0);
    add_vec(3'd0, 3'd4, 3'd0, 3'd1, 1,    1, 1'b1);
    add_vec(3'd2, 3'd0, 3'd0, 3'd1, 0,  129, 1'b0);

    @(negedge clk);
    @(negedge clk);
    check_outputs("reset");
    extern_reset_n = 1'b1;
    cycle(1'b0, 1'b0, 3'd0, "idle");

    // Table vectors, streamed back to back (next MSD on the result_valid cycle)
    foreach (tbl[k]) begin
      for (int i = 0; i < N; i++) begin
        cycle(1'b1, (i == 0), tbl[k].dig[i], "tbl_digit");
        if (i < N-1) gaps(tbl[k].gap);
      end
      check("tbl_value", int'($signed(result)), tbl[k].exp_val);
      check("tbl_valid", int'(result_valid), 1);
      check("tbl_error", int'(digit_error), int'(tbl[k].exp_err));
    end
    gaps(2);

    // Stray non-first digit while idle, then an aborted stream and a restart with stalls
    cycle(1'b1, 1'b0, 3'd3, "stray");
    cycle(1'b1, 1'b1, 3'd1, "abort_d0");
    gaps(3);
    cycle(1'b1, 1'b0, 3'd0, "abort_d1");
    gaps(3);
    cycle(1'b1, 1'b1, 3'd2, "restart_d0");
    gaps(3);
    cycle(1'b1, 1'b0, 3'd0, "restart_d1");
    gaps(3);
    cycle(1'b1, 1'b0, 3'd0, "restart_d2");
    gaps(3);
    cycle(1'b1, 1'b0, 3'd0, "restart_d3");
    check("restart_value", int'($signed(result)), 128);
    check("restart_valid", int'(result_valid), 1);
    gaps(2);

    // Asynchronous reset part way through a conversion
    cycle(1'b1, 1'b1, 3'd1, "pre_rst_d0");
    cycle(1'b1, 1'b0, 3'd2, "pre_rst_d1");
    do_reset();
    cycle(1'b1, 1'b1, 3'd2, "post_rst");
    cycle(1'b1, 1'b0, 3'd7, "post_rst");
    cycle(1'b1, 1'b0, 3'd0, "post_rst");
    cycle(1'b1, 1'b0, 3'd3, "post_rst");
    check("post_rst_value", int'($signed(result)), 115);
    gaps(1);

    // Random streams with stalls, restarts and illegal digits
    for (int r = 0; r < 600; r++) begin
      bit v;
      bit f;
      v = ($urandom % 4) != 0;
      f = v && (m_active ? (($urandom % 8) == 0) : (($urandom % 2) == 0));
      cycle(v, f, 3'($urandom_range(0, 7)), "rand");
    end
    gaps(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
